// File: rtl/brick_grid_store_pkg.sv
// brick_grid_store_pkg: grid defaults, FSM state encoding and cell address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package brick_grid_store_pkg;

  localparam int DEF_COLS    = 8;
  localparam int DEF_ROWS    = 4;
  localparam int DEF_BRICK_W = 40;
  localparam int DEF_BRICK_H = 20;
  localparam int PIX_W       = 10;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_FILL   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_HIT_RD = 3'd3,
    ST_HIT_WR = 3'd4
  } state_t;

  // Row-major cell index: row*COLS + col.
  function automatic int cell_addr(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/brick_grid_store_if.sv
// brick_grid_store_if: init/hit/lookup request and status bundle for brick_grid_store.
// Latency: n/a (wires only). Backpressure: hit side uses hit_valid/hit_ready.
// Modports: master = collision/draw side driving requests, slave = the store. Optional score with BRICK_SCORE_EN.
interface brick_grid_store_if #(
  parameter int COLS = 8,
  parameter int ROWS = 4,
  parameter int HP_W = 2
);
  import brick_grid_store_pkg::*;

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = $clog2(COLS * ROWS + 1);

  logic            init_req;
  logic [HP_W-1:0] init_hp;
  logic            init_busy;
  logic            hit_valid;
  logic [CW-1:0]   hit_col;
  logic [RW-1:0]   hit_row;
  logic            hit_ready;
  logic            destroyed;
  logic [CW-1:0]   rd_col;
  logic [RW-1:0]   rd_row;
  logic [HP_W-1:0] health;
  logic [PIX_W-1:0] x;
  logic [PIX_W-1:0] y;
  logic [LW-1:0]   bricks_left;
  logic            level_clear;
`ifdef BRICK_SCORE_EN
  logic [15:0]     score;
`endif

  modport master (
    output init_req, init_hp, hit_valid, hit_col, hit_row, rd_col, rd_row,
    input  init_busy, hit_ready, destroyed, health, x, y, bricks_left, level_clear
`ifdef BRICK_SCORE_EN
    , input score
`endif
  );

  modport slave (
    input  init_req, init_hp, hit_valid, hit_col, hit_row, rd_col, rd_row,
    output init_busy, hit_ready, destroyed, health, x, y, bricks_left, level_clear
`ifdef BRICK_SCORE_EN
    , output score
`endif
  );

endinterface

// File: rtl/brick_dpram.sv
// brick_dpram: dual-port RAM, port A read/write (sweep and hit RMW), port B read-only (lookup).
// Latency: 1 cycle on both read ports. Backpressure: none, accepts an access every cycle.
// Port B returns port A's write data when both address the same word in the same cycle.
module brick_dpram #(
  parameter int W     = 2,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [W-1:0]  a_wdat,
  output logic [W-1:0]  a_q,
  input  logic [AW-1:0] b_addr,
  output logic [W-1:0]  b_q
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdat;
    a_q <= mem[a_addr];
    b_q <= (a_we && (a_addr == b_addr)) ? a_wdat : mem[b_addr];
  end

endmodule

// File: rtl/brick_grid_store.sv
// brick_grid_store: COLS x ROWS brick health store with clear/fill sweep, hit RMW, lookup port and live count.
// Latency: lookup 1 cycle; hit 3 cycles (IDLE->HIT_RD->HIT_WR); sweeps N cycles. Backpressure: hit_ready only in IDLE.
// Ports: clk, resetn (sync, active-low), bus (brick_grid_store_if.slave). BRICK_SCORE_EN adds bus.score.
module brick_grid_store
  import brick_grid_store_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int HP_W    = 2,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int X0      = 0,
  parameter int Y0      = 0
) (
  input logic               clk,
  input logic               resetn,
  brick_grid_store_if.slave bus
);
  localparam int N  = COLS * ROWS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(N + 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt;
  logic             sweep_end;
  logic [HP_W-1:0]  fill_hp, pend_hp;
  logic             pend, req_now;
  logic             fill_start, fill_end, hit_acc, dec, kill;
  logic [AW-1:0]    h_addr;
  logic             h_ok;
  logic [AW-1:0]    a_addr, b_addr;
  logic             a_we;
  logic [HP_W-1:0]  a_wdat, a_q, b_q;
  logic             hit_in_range, rd_in_range, rd_ok_q;
  logic [LW-1:0]    left;
  logic [PIX_W-1:0] x_q, y_q;

  assign hit_in_range = (int'(bus.hit_col) < COLS) && (int'(bus.hit_row) < ROWS);
  assign rd_in_range  = (int'(bus.rd_col) < COLS) && (int'(bus.rd_row) < ROWS);
  // Out-of-range coordinates are steered to cell 0 so the RAM is never indexed past N-1.
  assign b_addr    = rd_in_range ? AW'(cell_addr(int'(bus.rd_row), int'(bus.rd_col), COLS)) : '0;
  assign sweep_end = (cnt == AW'(N - 1));
  // A request seen outside IDLE is honoured when the FSM would next return to IDLE.
  assign req_now   = pend | bus.init_req;

  always_comb begin
    state_nxt  = state;
    a_addr     = h_addr;
    a_we       = 1'b0;
    a_wdat     = '0;
    fill_start = 1'b0;
    fill_end   = 1'b0;
    hit_acc    = 1'b0;
    dec        = 1'b0;
    kill       = 1'b0;
    case (state)
      ST_CLEAR: begin
        a_addr = cnt;
        a_we   = 1'b1;
        if (sweep_end) begin
          state_nxt  = req_now ? ST_FILL : ST_IDLE;
          fill_start = req_now;
        end
      end
      ST_FILL: begin
        a_addr = cnt;
        a_we   = 1'b1;
        a_wdat = fill_hp;
        if (sweep_end) begin
          fill_end   = 1'b1;
          state_nxt  = req_now ? ST_FILL : ST_IDLE;
          fill_start = req_now;
        end
      end
      ST_IDLE: begin
        if (bus.init_req) begin
          state_nxt  = ST_FILL;
          fill_start = 1'b1;
        end else if (bus.hit_valid) begin
          state_nxt = ST_HIT_RD;
          hit_acc   = 1'b1;
        end
      end
      ST_HIT_RD: state_nxt = ST_HIT_WR;
      ST_HIT_WR: begin
        // a_q holds the health read during HIT_RD; empty cells are left untouched.
        if (h_ok && (a_q != '0)) begin
          a_we   = 1'b1;
          a_wdat = a_q - 1'b1;
          dec    = 1'b1;
          kill   = (a_q == HP_W'(1));
        end
        state_nxt  = req_now ? ST_FILL : ST_IDLE;
        fill_start = req_now;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_CLEAR;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      pend    <= 1'b0;
      pend_hp <= '0;
      fill_hp <= '0;
      h_addr  <= '0;
      h_ok    <= 1'b0;
      left    <= '0;
      rd_ok_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      if ((state == ST_CLEAR) || (state == ST_FILL))
        cnt <= sweep_end ? '0 : cnt + 1'b1;
      if (fill_start) begin
        pend    <= 1'b0;
        fill_hp <= bus.init_req ? bus.init_hp : pend_hp;
      end else if (bus.init_req && (state != ST_IDLE)) begin
        pend    <= 1'b1;
        pend_hp <= bus.init_hp;
      end
      if (hit_acc) begin
        h_ok   <= hit_in_range;
        h_addr <= hit_in_range ? AW'(cell_addr(int'(bus.hit_row), int'(bus.hit_col), COLS)) : '0;
      end
      if (fill_end)
        left <= (fill_hp == '0) ? '0 : LW'(N);
      else if (kill && (left != '0))
        left <= left - 1'b1;
      rd_ok_q <= rd_in_range;
      x_q     <= PIX_W'(X0 + int'(bus.rd_col) * BRICK_W);
      y_q     <= PIX_W'(Y0 + int'(bus.rd_row) * BRICK_H);
    end
  end

  // Writes are suppressed while reset is asserted so an aborted hit never lands.
  brick_dpram #(.W(HP_W), .DEPTH(N), .AW(AW)) u_ram (
    .clk    (clk),
    .a_addr (a_addr),
    .a_we   (a_we & resetn),
    .a_wdat (a_wdat),
    .a_q    (a_q),
    .b_addr (b_addr),
    .b_q    (b_q)
  );

`ifdef BRICK_SCORE_EN
  logic [15:0] score_q;
  always_ff @(posedge clk) begin
    if (!resetn)         score_q <= '0;
    else if (fill_start) score_q <= '0;
    else if (dec)        score_q <= score_q + (kill ? 16'd5 : 16'd1);
  end
  assign bus.score = score_q;
`endif

  // init_busy is masked by resetn so every output reads 0 while reset is held.
  assign bus.init_busy   = resetn & ((state == ST_CLEAR) || (state == ST_FILL));
  assign bus.hit_ready   = (state == ST_IDLE) & ~bus.init_req;
  assign bus.destroyed   = kill;
  assign bus.bricks_left = left;
  assign bus.level_clear = (state == ST_IDLE) && (left == '0);
  assign bus.health      = rd_ok_q ? b_q : '0;
  assign bus.x           = x_q;
  assign bus.y           = y_q;

endmodule

// File: tb/tb_brick_grid_store.sv
// tb_brick_grid_store: self-checking bench for brick_grid_store (8x4 default grid plus a 5x3 grid for out-of-range cells).
// Lookup expectations come from a bench-side health model and travel through a scoreboard queue.
// Inputs are driven 2 time units after the rising edge; outputs are sampled at the same point.
module tb_brick_grid_store;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  brick_grid_store_if #(.COLS(8), .ROWS(4), .HP_W(2)) bus  ();
  brick_grid_store_if #(.COLS(5), .ROWS(3), .HP_W(2)) bus2 ();

  brick_grid_store #(.COLS(8), .ROWS(4), .HP_W(2), .BRICK_W(40), .BRICK_H(20), .X0(0), .Y0(0)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  brick_grid_store #(.COLS(5), .ROWS(3), .HP_W(2), .BRICK_W(40), .BRICK_H(20), .X0(0), .Y0(0)) u_dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  int mdl [32];
  int left;

  typedef struct { int h; int x; int y; } look_t;
  look_t sbq [$];

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    #1;
    while (bus.init_busy && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic model_fill(input int v);
    for (int i = 0; i < 32; i++) mdl[i] = v;
    left = (v != 0) ? 32 : 0;
  endtask

  task automatic push_look(input int c, input int r);
    look_t e;
    bus.rd_col = 3'(c);
    bus.rd_row = 2'(r);
    e.h = mdl[r*8 + c];
    e.x = (c * 40) % 1024;
    e.y = (r * 20) % 1024;
    sbq.push_back(e);
  endtask

  task automatic pop_look();
    look_t e;
    if (sbq.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("look_health", bus.health, e.h);
      chk("look_x", bus.x, e.x);
      chk("look_y", bus.y, e.y);
    end
  endtask

  task automatic look(input int c, input int r);
    push_look(c, r);
    step();
    pop_look();
  endtask

  task automatic fill(input int v);
    int n;
    bus.init_req = 1'b1;
    bus.init_hp  = 2'(v);
    step();
    bus.init_req = 1'b0;
    wait_busy(n);
    chk("fill_busy_cycles", n, 32);
    model_fill(v);
    chk("fill_left", bus.bricks_left, left);
  endtask

  // lw: issue a lookup of the same cell during HIT_WR. pend_hp >= 0: pulse init_req during HIT_RD.
  task automatic do_hit(input int c, input int r, input bit lw, input int pend_hp);
    int n;
    int h;
    n = 0;
    while (!bus.hit_ready && n < 8) begin
      step();
      n++;
    end
    chk("hit_ready", bus.hit_ready, 1);
    bus.hit_valid = 1'b1;
    bus.hit_col   = 3'(c);
    bus.hit_row   = 2'(r);
    step();
    bus.hit_valid = 1'b0;
    if (pend_hp >= 0) begin
      bus.init_req = 1'b1;
      bus.init_hp  = 2'(pend_hp);
    end
    step();
    bus.init_req = 1'b0;
    h = mdl[r*8 + c];
    chk("hit_destroyed", bus.destroyed, (h == 1) ? 1 : 0);
    chk("hit_lvl_low", bus.level_clear, 0);
    if (h > 0) begin
      mdl[r*8 + c] = h - 1;
      if (h == 1 && left > 0) left--;
    end
    if (lw) push_look(c, r);
    step();
    chk("hit_pulse_1cyc", bus.destroyed, 0);
    if (lw) pop_look();
    if (pend_hp >= 0) begin
      chk("pend_fill_started", bus.init_busy, 1);
      wait_busy(n);
      chk("pend_fill_cycles", n, 32);
      model_fill(pend_hp);
    end
  endtask

  initial begin
    int n;
    bus.init_req = 0;  bus.init_hp = 0;  bus.hit_valid = 0;  bus.hit_col = 0;  bus.hit_row = 0;
    bus.rd_col = 0;    bus.rd_row = 0;
    bus2.init_req = 0; bus2.init_hp = 0; bus2.hit_valid = 0; bus2.hit_col = 0; bus2.hit_row = 0;
    bus2.rd_col = 0;   bus2.rd_row = 0;
    model_fill(0);

    // Reset state, then the clear sweep.
    repeat (3) step();
    chk("rst_busy", bus.init_busy, 0);
    chk("rst_ready", bus.hit_ready, 0);
    chk("rst_destroyed", bus.destroyed, 0);
    chk("rst_health", bus.health, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_left", bus.bricks_left, 0);
    chk("rst_lvl", bus.level_clear, 0);
    resetn = 1'b1;
    wait_busy(n);
    chk("clr_busy_cycles", n, 32);
    chk("clr_lvl", bus.level_clear, 1);
    chk("clr_ready", bus.hit_ready, 1);
    look(0, 0);
    look(7, 3);
    look(5, 2);

    // Fill with 3; (5,2) sits at x=200, y=40.
    fill(3);
    look(5, 2);
    look(7, 3);

    // Three hits take (1,1) from 3 to 0; only the last one destroys it.
    repeat (3) begin
      do_hit(1, 1, 1'b0, -1);
      look(1, 1);
    end
    chk("t3_left", bus.bricks_left, 31);
    do_hit(1, 1, 1'b0, -1);
    chk("t3_left_after_empty_hit", bus.bricks_left, 31);
    look(1, 1);
`ifdef BRICK_SCORE_EN
    // +1, +1, +1+4 for the destroying hit; the hit on an empty cell adds nothing.
    chk("t3_score", bus.score, 7);
`endif

    // Fill 1 and clear the whole field.
    fill(1);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (r == 3 && c == 7) chk("t4_lvl_before_last", bus.level_clear, 0);
        do_hit(c, r, 1'b0, -1);
      end
    end
    chk("t4_lvl_after_last", bus.level_clear, 1);
    chk("t4_left", bus.bricks_left, 0);
    do_hit(4, 2, 1'b0, -1);
    chk("t4_left_saturates", bus.bricks_left, 0);

    // Read-during-write forwarding, and an init_req latched during a hit.
    fill(3);
    do_hit(0, 0, 1'b1, -1);
    do_hit(2, 1, 1'b0, 2);
    chk("t5_left_after_pend_fill", bus.bricks_left, 32);
    look(2, 1);
    look(0, 0);

    // Reset during FILL with a second request latched: only the clear sweep follows.
    bus.init_req = 1'b1;
    bus.init_hp  = 2'd3;
    step();
    bus.init_req = 1'b0;
    repeat (3) step();
    chk("t6_in_fill", bus.init_busy, 1);
    bus.init_req = 1'b1;
    bus.init_hp  = 2'd1;
    step();
    bus.init_req = 1'b0;
    resetn = 1'b0;
    step();
    chk("t6a_rst_busy", bus.init_busy, 0);
    chk("t6a_rst_left", bus.bricks_left, 0);
    chk("t6a_rst_health", bus.health, 0);
    chk("t6a_rst_lvl", bus.level_clear, 0);
    chk("t6a_rst_ready", bus.hit_ready, 0);
    resetn = 1'b1;
    wait_busy(n);
    chk("t6a_clr_only", n, 32);
    model_fill(0);
    chk("t6a_lvl", bus.level_clear, 1);
    look(4, 1);

    // Reset during HIT_WR with a request latched during HIT_RD.
    fill(2);
    bus.hit_valid = 1'b1;
    bus.hit_col   = 3'd2;
    bus.hit_row   = 2'd2;
    step();
    bus.hit_valid = 1'b0;
    bus.init_req  = 1'b1;
    bus.init_hp   = 2'd3;
    step();
    bus.init_req  = 1'b0;
    chk("t6b_hitwr_ready", bus.hit_ready, 0);
    resetn = 1'b0;
    step();
    chk("t6b_rst_destroyed", bus.destroyed, 0);
    chk("t6b_rst_left", bus.bricks_left, 0);
    chk("t6b_rst_health", bus.health, 0);
    resetn = 1'b1;
    wait_busy(n);
    chk("t6b_clr_only", n, 32);
    model_fill(0);
    look(2, 2);
    chk("t6b_lvl", bus.level_clear, 1);

    // 5x3 grid: coordinates beyond the grid are accepted but have no effect.
    bus2.init_req = 1'b1;
    bus2.init_hp  = 2'd2;
    step();
    bus2.init_req = 1'b0;
    n = 0;
    while (bus2.init_busy && n < 100) begin
      n++;
      step();
    end
    chk("g2_fill_cycles", n, 15);
    chk("g2_left", bus2.bricks_left, 15);
    bus2.hit_valid = 1'b1;
    bus2.hit_col   = 3'd6;
    bus2.hit_row   = 2'd0;
    step();
    bus2.hit_valid = 1'b0;
    step();
    chk("g2_oor_no_pulse", bus2.destroyed, 0);
    repeat (2) step();
    chk("g2_oor_left", bus2.bricks_left, 15);
    bus2.rd_col = 3'd6;
    bus2.rd_row = 2'd1;
    step();
    chk("g2_oor_col_health", bus2.health, 0);
    bus2.rd_col = 3'd4;
    bus2.rd_row = 2'd2;
    step();
    chk("g2_health", bus2.health, 2);
    chk("g2_x", bus2.x, 160);
    chk("g2_y", bus2.y, 40);
    bus2.rd_col = 3'd0;
    bus2.rd_row = 2'd3;
    step();
    chk("g2_oor_row_health", bus2.health, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
